// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit word out MSB-first, repeated
// a programmable number of times with an optional idle gap between copies.
module serial_pattern_tx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [3:0]       reps,
    output logic             x,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] BitMax  = CntW'(WIDTH - 1);
    localparam logic [3:0]      GapLoad = 4'(GAP);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  held_q, held_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CntW-1:0]   bit_q, bit_d;
    logic [3:0]        copy_q, copy_d;
    logic [3:0]        gap_q, gap_d;
    logic              x_d, last_d, busy_d, done_d;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        copy_d  = copy_q;
        gap_d   = gap_q;

        case (state_q)
            StIdle: begin
                if (start && (reps != 4'd0)) begin
                    held_d  = data;
                    shift_d = data;
                    copy_d  = reps;
                    bit_d   = BitMax;
                    state_d = StSend;
                end
            end
            StSend: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                bit_d   = bit_q - 1'b1;
                if (bit_q == '0) begin
                    if (copy_q > 4'd1) begin
                        copy_d  = copy_q - 4'd1;
                        shift_d = held_q;
                        if (GAP > 0) begin
                            // Bit counter is reloaded when the gap ends.
                            bit_d   = '0;
                            gap_d   = GapLoad;
                            state_d = StGap;
                        end else begin
                            bit_d = BitMax;
                        end
                    end else begin
                        bit_d   = '0;
                        state_d = StDone;
                    end
                end
            end
            StGap: begin
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1) begin
                    bit_d   = BitMax;
                    state_d = StSend;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from next-state values so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        x_d    = (state_d == StSend) && shift_d[WIDTH-1];
        last_d = (state_d == StSend) && (bit_d == '0);
        busy_d = (state_d == StSend) || (state_d == StGap);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            held_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            copy_q  <= '0;
            gap_q   <= '0;
            x       <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            copy_q  <= copy_d;
            gap_q   <= gap_d;
            x       <= x_d;
            last    <= last_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: one instance with GAP=0 and one with
// GAP=2 share stimulus; each has its own expected-output queue and monitor.
module tb_serial_pattern_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] data;
    logic [3:0] reps;
    logic       x0, last0, busy0, done0;
    logic       x2, last2, busy2, done2;

    int checks = 0;
    int fails  = 0;

    // Entries are {x, last, busy, done}
    logic [3:0] q0[$];
    logic [3:0] q2[$];

    serial_pattern_tx #(.WIDTH(4), .GAP(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (data),
        .reps  (reps),
        .x     (x0),
        .last  (last0),
        .busy  (busy0),
        .done  (done0)
    );

    serial_pattern_tx #(.WIDTH(4), .GAP(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (data),
        .reps  (reps),
        .x     (x2),
        .last  (last2),
        .busy  (busy2),
        .done  (done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int gap, input logic [3:0] d, input int r);
        logic [3:0] e;
        for (int c = 0; c < r; c++) begin
            if (c > 0) begin
                for (int g = 0; g < gap; g++) begin
                    e = 4'b0010;
                    if (gap == 0) q0.push_back(e); else q2.push_back(e);
                end
            end
            for (int b = 3; b >= 0; b--) begin
                e = {d[b], (b == 0), 1'b1, 1'b0};
                if (gap == 0) q0.push_back(e); else q2.push_back(e);
            end
        end
        if (r > 0) begin
            e = 4'b0001;
            if (gap == 0) q0.push_back(e); else q2.push_back(e);
        end
    endtask

    task automatic check_zero(input string name, input logic [3:0] act);
        checks++;
        if (act !== 4'b0000) begin
            fails++;
            $display("FAIL %s: got x/last/busy/done=%b, want 0000", name, act);
        end
    endtask

    // Called at posedge+2; the start pulse is sampled on the next edge.
    task automatic pulse_start(input logic [3:0] d, input logic [3:0] r);
        push_exp(0, d, int'(r));
        push_exp(2, d, int'(r));
        data  = d;
        reps  = r;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() != 0 || q2.size() != 0) && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 400) begin
            fails++;
            $display("FAIL idle_timeout: %0d/%0d entries left, want 0", q0.size(), q2.size());
            q0.delete();
            q2.delete();
        end
        @(posedge clk);
        #2;
    endtask

    initial begin : mon0
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (reset && (busy0 || done0)) begin
                checks++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL gap0_unexpected: got %b, want no output", {x0, last0, busy0, done0});
                end else begin
                    e = q0.pop_front();
                    if ({x0, last0, busy0, done0} !== e) begin
                        fails++;
                        $display("FAIL gap0_seq: got %b, want %b", {x0, last0, busy0, done0}, e);
                    end
                end
            end
        end
    end

    initial begin : mon2
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (reset && (busy2 || done2)) begin
                checks++;
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL gap2_unexpected: got %b, want no output", {x2, last2, busy2, done2});
                end else begin
                    e = q2.pop_front();
                    if ({x2, last2, busy2, done2} !== e) begin
                        fails++;
                        $display("FAIL gap2_seq: got %b, want %b", {x2, last2, busy2, done2}, e);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b1;
        data  = 4'b1010;
        reps  = 4'd1;
        repeat (2) begin
            @(negedge clk);
            check_zero("reset_gap0", {x0, last0, busy0, done0});
            check_zero("reset_gap2", {x2, last2, busy2, done2});
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #2;

        // Single word, back-to-back repeats, gap repeats.
        pulse_start(4'b1010, 4'd1);
        wait_idle();
        pulse_start(4'b1010, 4'd3);
        wait_idle();
        pulse_start(4'b1101, 4'd2);
        wait_idle();

        // start and data changes during SEND are ignored.
        pulse_start(4'b1100, 4'd2);
        @(posedge clk);
        #2;
        start = 1'b1;
        data  = 4'b0110;
        @(posedge clk);
        #2 start = 1'b0;
        wait_idle();

        // reps=0 never leaves IDLE.
        pulse_start(4'b1111, 4'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_zero("reps0_gap0", {x0, last0, busy0, done0});
        check_zero("reps0_gap2", {x2, last2, busy2, done2});
        @(posedge clk);
        #2;

        // Asynchronous reset during bit 2 of a 3-copy send.
        pulse_start(4'b1010, 4'd3);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_zero("midreset_gap0", {x0, last0, busy0, done0});
        check_zero("midreset_gap2", {x2, last2, busy2, done2});
        q0.delete();
        q2.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2;
        pulse_start(4'b0011, 4'd1);
        wait_idle();

        repeat (4) @(posedge clk);
        checks++;
        if (q0.size() != 0 || q2.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d/%0d entries, want 0", q0.size(), q2.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
